vga_sync_controller: RTL and testbench

Timing sequencer for the VGA signal path: divides the 100 MHz system clock to the 25 MHz pixel rate and steps the horizontal and vertical counters through the active, front porch, sync and back porch segments. It produces the hsync, vsync, video_on and pixel-position outputs consumed by the pixel generator. It replaces free-running counter pairs with an enable-gated, segment-aware controller.

---
 rtl/vga_timing_pkg.sv | 26 ++
 rtl/vga_axis_fsm.sv | 74 +++++++
 rtl/vga_sync_controller.sv | 100 ++++++++++
 tb/tb_vga_sync_controller.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and default 640x480@60 constants for the sync controller.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    ACTIVE,
    FRONT,
    SYNC,
    BACK
  } axis_state_e;

  localparam int POS_W     = 10;
  localparam int MAX_TOTAL = 1 << POS_W;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;

  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  localparam int DEF_CLK_DIV  = 4;

endpackage

// File: rtl/vga_axis_fsm.sv
// One display axis: walks ACTIVE/FRONT/SYNC/BACK segments and keeps the absolute position.
module vga_axis_fsm
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE_LEN = DEF_H_ACTIVE,
  parameter int FP_LEN     = DEF_H_FP,
  parameter int SYNC_LEN   = DEF_H_SYNC,
  parameter int BP_LEN     = DEF_H_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             advance,
  output logic [POS_W-1:0] pos,
  output axis_state_e      state,
  output logic             wrap
);

  axis_state_e      state_next;
  logic [POS_W-1:0] seg;
  logic [POS_W-1:0] seg_next;
  logic [POS_W-1:0] seg_last;
  logic [POS_W-1:0] pos_next;
  logic             step;

  assign step = en & advance;

  always_comb begin
    case (state)
      ACTIVE:  seg_last = POS_W'(ACTIVE_LEN - 1);
      FRONT:   seg_last = POS_W'(FP_LEN - 1);
      SYNC:    seg_last = POS_W'(SYNC_LEN - 1);
      default: seg_last = POS_W'(BP_LEN - 1);
    endcase
  end

  // Level flag for the last position of the axis; the caller qualifies it with its advance.
  assign wrap = (state == BACK) && (seg == seg_last);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_next = state;
    seg_next   = seg;
    pos_next   = pos;
    if (step) begin
      if (seg == seg_last) begin
        seg_next = '0;
        case (state)
          ACTIVE:  state_next = FRONT;
          FRONT:   state_next = SYNC;
          SYNC:    state_next = BACK;
          default: state_next = ACTIVE;
        endcase
      end else begin
        seg_next = seg + 1'b1;
      end
      pos_next = wrap ? '0 : pos + 1'b1;
    end
  end

  // NOTE: registers use non-blocking assignments so all state updates land together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ACTIVE;
      seg   <= '0;
      pos   <= '0;
    end else begin
      state <= state_next;
      seg   <= seg_next;
      pos   <= pos_next;
    end
  end

endmodule

// File: rtl/vga_sync_controller.sv
// VGA timing sequencer: pixel-rate divider, chained horizontal/vertical axis FSMs, sync decodes.
module vga_sync_controller
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int CLK_DIV  = DEF_CLK_DIV
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic             pix_tick,
  output logic [POS_W-1:0] x,
  output logic [POS_W-1:0] y,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_start,
  output logic             frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DIV_W   = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_total
    $fatal(1, "vga_sync_controller: H_TOTAL=%0d / V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL,
           MAX_TOTAL);
  end
  if (CLK_DIV < 2 || CLK_DIV > 16) begin : g_bad_div
    $fatal(1, "vga_sync_controller: CLK_DIV=%0d outside 2..16", CLK_DIV);
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_seg
    $fatal(1, "vga_sync_controller: every segment length must be at least 1");
  end

  logic [DIV_W-1:0] div;
  logic             run;
  logic             h_wrap;
  logic             v_wrap;
  axis_state_e      h_state;
  axis_state_e      v_state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div <= '0;
    end else if (en) begin
      div <= (div == DIV_LAST) ? '0 : div + 1'b1;
    end
  end

  // Gating with rst keeps video_on low while reset holds both axes in ACTIVE.
  assign run         = en & rst;
  assign pix_tick    = run & (div == DIV_LAST);
  assign line_start  = pix_tick & h_wrap;
  assign frame_start = line_start & v_wrap;
  assign video_on    = run & (h_state == ACTIVE) & (v_state == ACTIVE);
  assign hsync       = ~(h_state == SYNC);
  assign vsync       = ~(v_state == SYNC);

  vga_axis_fsm #(
    .ACTIVE_LEN (H_ACTIVE),
    .FP_LEN     (H_FP),
    .SYNC_LEN   (H_SYNC),
    .BP_LEN     (H_BP)
  ) u_h_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .advance (pix_tick),
    .pos     (x),
    .state   (h_state),
    .wrap    (h_wrap)
  );

  // y steps only on the pixel that wraps x back to 0.
  vga_axis_fsm #(
    .ACTIVE_LEN (V_ACTIVE),
    .FP_LEN     (V_FP),
    .SYNC_LEN   (V_SYNC),
    .BP_LEN     (V_BP)
  ) u_v_axis (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .advance (line_start),
    .pos     (y),
    .state   (v_state),
    .wrap    (v_wrap)
  );

endmodule

// File: tb/tb_vga_sync_controller.sv
// Directed bench: default 640x480 instance for line/enable checks, tiny instance for frame/reset checks.
module tb_vga_sync_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       d_rst, d_en, d_pix_tick, d_hsync, d_vsync, d_video_on, d_line_start, d_frame_start;
  logic [9:0] d_x, d_y;
  logic       s_rst, s_en, s_pix_tick, s_hsync, s_vsync, s_video_on, s_line_start, s_frame_start;
  logic [9:0] s_x, s_y;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  vga_sync_controller u_dut_def (
    .clk         (clk),
    .rst         (d_rst),
    .en          (d_en),
    .pix_tick    (d_pix_tick),
    .x           (d_x),
    .y           (d_y),
    .hsync       (d_hsync),
    .vsync       (d_vsync),
    .video_on    (d_video_on),
    .line_start  (d_line_start),
    .frame_start (d_frame_start)
  );

  vga_sync_controller #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (2), .H_BP (2),
    .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
    .CLK_DIV  (2)
  ) u_dut_small (
    .clk         (clk),
    .rst         (s_rst),
    .en          (s_en),
    .pix_tick    (s_pix_tick),
    .x           (s_x),
    .y           (s_y),
    .hsync       (s_hsync),
    .vsync       (s_vsync),
    .video_on    (s_video_on),
    .line_start  (s_line_start),
    .frame_start (s_frame_start)
  );

  // {x, y, hsync, vsync, video_on, pix_tick, line_start, frame_start} while in reset
  localparam logic [25:0] RESET_VEC = {10'd0, 10'd0, 6'b110000};

  task automatic step();
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic [25:0] obs;
    d_rst = 1'b0; s_rst = 1'b0; d_en = 1'b1; s_en = 1'b1;
    #2;
    obs = {d_x, d_y, d_hsync, d_vsync, d_video_on, d_pix_tick, d_line_start, d_frame_start};
    total++;
    if (obs !== RESET_VEC) begin
      bad++; $display("FAIL reset_def: got %h want %h", obs, RESET_VEC);
    end
    obs = {s_x, s_y, s_hsync, s_vsync, s_video_on, s_pix_tick, s_line_start, s_frame_start};
    total++;
    if (obs !== RESET_VEC) begin
      bad++; $display("FAIL reset_small: got %h want %h", obs, RESET_VEC);
    end
    step(); step(); step(); step();
    obs = {d_x, d_y, d_hsync, d_vsync, d_video_on, d_pix_tick, d_line_start, d_frame_start};
    total++;
    if (obs !== RESET_VEC) begin
      bad++; $display("FAIL reset_held: got %h want %h", obs, RESET_VEC);
    end
  endtask

  task automatic test_first_tick();
    bit exp_tick[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    int exp_x[8]    = '{0, 0, 0, 1, 1, 1, 1, 2};
    d_rst = 1'b1;
    cyc   = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      total++;
      if (d_pix_tick !== exp_tick[k]) begin
        bad++; $display("FAIL first_tick clk%0d: got %b want %b", k + 1, d_pix_tick, exp_tick[k]);
      end
      total++;
      if (int'(d_x) !== exp_x[k]) begin
        bad++; $display("FAIL x_step clk%0d: got %0d want %0d", k + 1, d_x, exp_x[k]);
      end
    end
  endtask

  task automatic test_video_on();
    while (cyc < 2559) step();
    total++;
    if (!(int'(d_x) === 639 && d_video_on === 1'b1)) begin
      bad++; $display("FAIL video_on_639: got x=%0d von=%b want x=639 von=1", d_x, d_video_on);
    end
    step();
    total++;
    if (!(int'(d_x) === 640 && d_video_on === 1'b0)) begin
      bad++; $display("FAIL video_on_640: got x=%0d von=%b want x=640 von=0", d_x, d_video_on);
    end
  endtask

  task automatic test_line();
    int fall = -1, rise = -1, fall_x = -1, rise_x = -1;
    int ls1 = -1, ls2 = -1, ls1_x = -1;
    int ych = -1, ych_x = -1, ych_y = -1;
    int fs_seen = 0, vs_low = 0;
    logic       prev_h = d_hsync;
    logic [9:0] prev_y = d_y;
    while (cyc < 6400) begin
      step();
      if (prev_h && !d_hsync && fall < 0) begin fall = cyc; fall_x = int'(d_x); end
      if (!prev_h && d_hsync && rise < 0) begin rise = cyc; rise_x = int'(d_x); end
      if (d_line_start) begin
        if (ls1 < 0) begin ls1 = cyc; ls1_x = int'(d_x); end
        else if (ls2 < 0) ls2 = cyc;
      end
      if (d_y !== prev_y && ych < 0) begin ych = cyc; ych_x = int'(d_x); ych_y = int'(d_y); end
      if (d_frame_start) fs_seen++;
      if (!d_vsync) vs_low++;
      prev_h = d_hsync;
      prev_y = d_y;
    end
    total++;
    if (fall !== 2624 || fall_x !== 656) begin
      bad++; $display("FAIL hsync_fall: got clk%0d x=%0d want clk2624 x=656", fall, fall_x);
    end
    total++;
    if (rise !== 3008 || rise_x !== 752) begin
      bad++; $display("FAIL hsync_rise: got clk%0d x=%0d want clk3008 x=752", rise, rise_x);
    end
    total++;
    if (ls1 !== 3199 || ls1_x !== 799) begin
      bad++; $display("FAIL line_start_1: got clk%0d x=%0d want clk3199 x=799", ls1, ls1_x);
    end
    total++;
    if (ls2 - ls1 !== 3200) begin
      bad++; $display("FAIL line_period: got %0d want 3200", ls2 - ls1);
    end
    total++;
    if (ych !== 3200 || ych_x !== 0 || ych_y !== 1) begin
      bad++; $display("FAIL y_step: got clk%0d x=%0d y=%0d want clk3200 x=0 y=1", ych, ych_x, ych_y);
    end
    total++;
    if (fs_seen !== 0 || vs_low !== 0) begin
      bad++; $display("FAIL early_frame: got fs=%0d vs_low=%0d want 0 0", fs_seen, vs_low);
    end
  endtask

  task automatic test_enable();
    int moved = 0, spurious = 0;
    while (cyc < 6800) step();
    total++;
    if (!(int'(d_x) === 100 && int'(d_y) === 2)) begin
      bad++; $display("FAIL pre_hold: got x=%0d y=%0d want x=100 y=2", d_x, d_y);
    end
    d_en = 1'b0;
    #1;
    total++;
    if (!(d_video_on === 1'b0 && d_pix_tick === 1'b0 && d_hsync === 1'b1)) begin
      bad++; $display("FAIL hold_decode: got von=%b tick=%b hs=%b want 0 0 1",
                      d_video_on, d_pix_tick, d_hsync);
    end
    for (int k = 0; k < 500; k++) begin
      step();
      if (int'(d_x) !== 100 || int'(d_y) !== 2 || d_hsync !== 1'b1) moved++;
      if (d_pix_tick || d_video_on || d_line_start || d_frame_start) spurious++;
    end
    total++;
    if (moved !== 0 || spurious !== 0) begin
      bad++; $display("FAIL hold_500: got moved=%0d spurious=%0d want 0 0", moved, spurious);
    end
    d_en = 1'b1;
    step(); step(); step();
    total++;
    if (!(int'(d_x) === 100 && d_pix_tick === 1'b1 && d_video_on === 1'b1)) begin
      bad++; $display("FAIL resume_tick: got x=%0d tick=%b von=%b want 100 1 1",
                      d_x, d_pix_tick, d_video_on);
    end
    step();
    total++;
    if (int'(d_x) !== 101) begin
      bad++; $display("FAIL resume_x: got %0d want 101", d_x);
    end
  endtask

  task automatic test_small_params();
    int fs1 = -1, fs2 = -1, hmin = 1023, hmax = -1, vmin = 1023, vmax = -1, von = 0;
    int x196 = -1, y196 = -1;
    s_rst = 1'b1;
    for (int k = 1; k <= 400; k++) begin
      step();
      if (s_frame_start) begin
        if (fs1 < 0) fs1 = k;
        else if (fs2 < 0) fs2 = k;
      end
      if (!s_hsync) begin
        if (int'(s_x) < hmin) hmin = int'(s_x);
        if (int'(s_x) > hmax) hmax = int'(s_x);
      end
      if (!s_vsync) begin
        if (int'(s_y) < vmin) vmin = int'(s_y);
        if (int'(s_y) > vmax) vmax = int'(s_y);
      end
      if (k <= 196 && s_video_on) von++;
      if (k == 196) begin x196 = int'(s_x); y196 = int'(s_y); end
    end
    total++;
    if (fs1 !== 195) begin
      bad++; $display("FAIL small_frame_start: got clk%0d want clk195", fs1);
    end
    total++;
    if (fs2 - fs1 !== 196) begin
      bad++; $display("FAIL small_frame_period: got %0d want 196", fs2 - fs1);
    end
    total++;
    if (x196 !== 0 || y196 !== 0) begin
      bad++; $display("FAIL small_wrap_pos: got x=%0d y=%0d want 0 0", x196, y196);
    end
    total++;
    if (hmin !== 10 || hmax !== 11) begin
      bad++; $display("FAIL small_hsync_span: got %0d..%0d want 10..11", hmin, hmax);
    end
    total++;
    if (vmin !== 5 || vmax !== 5) begin
      bad++; $display("FAIL small_vsync_span: got %0d..%0d want 5..5", vmin, vmax);
    end
    total++;
    if (von !== 64) begin
      bad++; $display("FAIL small_video_on_count: got %0d want 64", von);
    end
  endtask

  task automatic test_reset_midframe();
    logic [25:0] obs;
    int budget = 300;
    while (!(int'(s_y) === 2 && int'(s_x) === 10) && budget > 0) begin
      step();
      budget--;
    end
    total++;
    if (budget == 0) begin
      bad++; $display("FAIL midframe_reach: got x=%0d y=%0d want x=10 y=2", s_x, s_y);
    end else if (s_hsync !== 1'b0) begin
      bad++; $display("FAIL midframe_sync: got hs=%b want 0", s_hsync);
    end
    #2 s_rst = 1'b0;
    #1;
    obs = {s_x, s_y, s_hsync, s_vsync, s_video_on, s_pix_tick, s_line_start, s_frame_start};
    total++;
    if (obs !== RESET_VEC) begin
      bad++; $display("FAIL async_reset: got %h want %h", obs, RESET_VEC);
    end
    step(); step();
    s_rst = 1'b1;
    step();
    total++;
    if (!(s_pix_tick === 1'b1 && int'(s_x) === 0 && int'(s_y) === 0)) begin
      bad++; $display("FAIL restart_tick: got tick=%b x=%0d y=%0d want 1 0 0", s_pix_tick, s_x, s_y);
    end
    step();
    total++;
    if (!(s_pix_tick === 1'b0 && int'(s_x) === 1)) begin
      bad++; $display("FAIL restart_x: got tick=%b x=%0d want 0 1", s_pix_tick, s_x);
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_video_on();
    test_line();
    test_enable();
    test_small_params();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
